// File: rtl/coin_change_dispenser.sv
// Greedy change dispenser: sums inserted coins, pays the overpayment back as
// 5000/2000/1000 eject pulses with per-coin ack. Optional stock: DISP_INVENTORY_EN.
module coin_change_dispenser #(
    parameter int INV_5000 = 64,
    parameter int INV_2000 = 64,
    parameter int INV_1000 = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [18:0] count_m,
    input  logic [8:0]  c_1000,
    input  logic [7:0]  c_2000,
    input  logic [6:0]  c_5000,
    input  logic        disp_ack,
    output logic        disp_1000,
    output logic        disp_2000,
    output logic        disp_5000,
    output logic        busy,
    output logic        done,
    output logic        underpay,
    output logic        shortfall,
    output logic [20:0] remainder
);

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        CMP,
        PICK,
        ISSUE,
        WAIT_ACK,
        DONE
    } state_t;

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_1000 = 2'd1;
    localparam logic [1:0] SEL_2000 = 2'd2;
    localparam logic [1:0] SEL_5000 = 2'd3;

    state_t      state;
    state_t      state_n;
    logic [18:0] target;
    logic [8:0]  n_1000;
    logic [7:0]  n_2000;
    logic [6:0]  n_5000;
    logic [20:0] p_1000;
    logic [20:0] p_2000;
    logic [20:0] p_5000;
    logic [20:0] total;
    logic [20:0] change;
    logic [20:0] step;
    logic [1:0]  sel;
    logic [1:0]  pick;
    logic        calc_ph;
    logic        have_5000;
    logic        have_2000;
    logic        have_1000;

`ifdef DISP_INVENTORY_EN
    logic [8:0]  stock_5000;
    logic [8:0]  stock_2000;
    logic [8:0]  stock_1000;
    logic        short_q;

    assign have_5000 = (stock_5000 != 9'd0);
    assign have_2000 = (stock_2000 != 9'd0);
    assign have_1000 = (stock_1000 != 9'd0);
    assign shortfall = short_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stock_5000 <= 9'(INV_5000);
            stock_2000 <= 9'(INV_2000);
            stock_1000 <= 9'(INV_1000);
            short_q    <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                short_q <= 1'b0;
            end
            if (state == PICK && pick == SEL_NONE) begin
                short_q <= (change >= 21'd1000);
            end
            if (state == ISSUE) begin
                case (sel)
                    SEL_5000: stock_5000 <= stock_5000 - 9'd1;
                    SEL_2000: stock_2000 <= stock_2000 - 9'd1;
                    SEL_1000: stock_1000 <= stock_1000 - 9'd1;
                    default:  ;
                endcase
            end
        end
    end
`else
    logic [8:0]  unused_inv;

    // Unlimited supply: stock parameters have no effect in this build.
    assign unused_inv = 9'(INV_5000) ^ 9'(INV_2000) ^ 9'(INV_1000);
    assign have_5000  = 1'b1;
    assign have_2000  = 1'b1;
    assign have_1000  = 1'b1;
    assign shortfall  = 1'b0;
`endif

    always_comb begin
        pick = SEL_NONE;
        if (change >= 21'd5000 && have_5000) begin
            pick = SEL_5000;
        end else if (change >= 21'd2000 && have_2000) begin
            pick = SEL_2000;
        end else if (change >= 21'd1000 && have_1000) begin
            pick = SEL_1000;
        end
    end

    always_comb begin
        case (sel)
            SEL_5000: step = 21'd5000;
            SEL_2000: step = 21'd2000;
            SEL_1000: step = 21'd1000;
            default:  step = 21'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (start) state_n = CALC;
            CALC:     if (calc_ph) state_n = CMP;
            CMP: begin
                if (total < {2'b00, target}) begin
                    state_n = DONE;
                end else begin
                    state_n = PICK;
                end
            end
            PICK: begin
                if (pick == SEL_NONE) begin
                    state_n = DONE;
                end else begin
                    state_n = ISSUE;
                end
            end
            ISSUE:    state_n = WAIT_ACK;
            WAIT_ACK: if (disp_ack) state_n = PICK;
            DONE:     state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // CALC spends two cycles: products first, then their sum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            target    <= '0;
            n_1000    <= '0;
            n_2000    <= '0;
            n_5000    <= '0;
            p_1000    <= '0;
            p_2000    <= '0;
            p_5000    <= '0;
            total     <= '0;
            change    <= '0;
            sel       <= SEL_NONE;
            calc_ph   <= 1'b0;
            underpay  <= 1'b0;
            remainder <= '0;
            done      <= 1'b0;
        end else begin
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        target    <= count_m;
                        n_1000    <= c_1000;
                        n_2000    <= c_2000;
                        n_5000    <= c_5000;
                        underpay  <= 1'b0;
                        remainder <= '0;
                        calc_ph   <= 1'b0;
                    end
                end
                CALC: begin
                    calc_ph <= ~calc_ph;
                    if (!calc_ph) begin
                        p_1000 <= 21'(n_1000) * 21'd1000;
                        p_2000 <= 21'(n_2000) * 21'd2000;
                        p_5000 <= 21'(n_5000) * 21'd5000;
                    end else begin
                        total <= p_1000 + p_2000 + p_5000;
                    end
                end
                CMP: begin
                    if (total < {2'b00, target}) begin
                        underpay  <= 1'b1;
                        remainder <= '0;
                    end else begin
                        change <= total - {2'b00, target};
                    end
                end
                PICK: begin
                    sel <= pick;
                    if (pick == SEL_NONE) begin
                        remainder <= change;
                    end
                end
                ISSUE: begin
                    change <= change - step;
                end
                default: ;
            endcase
        end
    end

    assign disp_5000 = (state == ISSUE) && (sel == SEL_5000);
    assign disp_2000 = (state == ISSUE) && (sel == SEL_2000);
    assign disp_1000 = (state == ISSUE) && (sel == SEL_1000);
    assign busy      = (state != IDLE);

endmodule
